// File: rtl/oqpsk_halfsine_mod.sv
// OQPSK modulator with half-sine pulse shaping: chips alternate onto I and Q,
// with Q offset by half a symbol, emitting one signed 4-bit I/Q sample per CLK_PER_SAMPLE clocks.
module oqpsk_halfsine_mod #(
    parameter int CLK_PER_SAMPLE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_chip,
    input  logic              i_chip_valid,
    output logic              o_chip_ready,
    output logic signed [3:0] o_i,
    output logic signed [3:0] o_q,
    output logic              o_sample_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_dbg_state
);

    localparam int DW = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_PER_SAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [DW-1:0]     div;
    logic [1:0]        p;
    logic [1:0]        drain_cnt;
    logic              ch_i_act, ch_i_pos, ch_q_act, ch_q_pos;
    logic              tick;
    logic              reload_slot;
    logic [1:0]        q_idx;
    logic signed [3:0] samp_i, samp_q;

    // Signed half-sine sample for one channel; an inactive channel contributes zero.
    function automatic logic signed [3:0] shape(input logic act, input logic pos,
                                                input logic [1:0] idx);
        logic signed [3:0] h;
        logic signed [3:0] r;
        case (idx)
            2'd0:    h = 4'sd0;
            2'd1:    h = 4'sd5;
            2'd2:    h = 4'sd7;
            default: h = 4'sd5;
        endcase
        r = 4'sd0;
        if (act) r = pos ? h : -h;
        return r;
    endfunction

    assign tick         = (div == DIV_LAST);
    assign reload_slot  = (state == RUN) && tick && p[0];
    assign o_chip_ready = (state == IDLE) || reload_slot;
    assign o_busy       = (state != IDLE);
    assign o_dbg_state  = state;
    assign q_idx        = p + 2'd2;
    assign samp_i       = shape(ch_i_act, ch_i_pos, p);
    assign samp_q       = shape(ch_q_act, ch_q_pos, q_idx);

    // Handshake: a chip moves only on an edge where i_chip_valid and o_chip_ready are
    // both high; o_chip_ready depends on state/counters only, never on i_chip_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            div            <= '0;
            p              <= 2'd0;
            drain_cnt      <= 2'd0;
            ch_i_act       <= 1'b0;
            ch_i_pos       <= 1'b0;
            ch_q_act       <= 1'b0;
            ch_q_pos       <= 1'b0;
            o_i            <= 4'sd0;
            o_q            <= 4'sd0;
            o_sample_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_chip_valid) begin
                        ch_i_act  <= 1'b1;
                        ch_i_pos  <= i_chip;
                        ch_q_act  <= 1'b0;
                        p         <= 2'd0;
                        div       <= '0;
                        drain_cnt <= 2'd0;
                        state     <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick) begin
                        p              <= p + 2'd1;
                        o_sample_valid <= 1'b1;
                        if (state == DRAIN && drain_cnt == 2'd2) begin
                            o_i      <= 4'sd0;
                            o_q      <= 4'sd0;
                            ch_i_act <= 1'b0;
                            ch_q_act <= 1'b0;
                            o_done   <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            o_i <= samp_i;
                            o_q <= samp_q;
                        end
                        if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
                        // p=1 reloads Q, p=3 reloads I; a missing chip starts the drain.
                        if (state == RUN && p[0]) begin
                            if (i_chip_valid) begin
                                if (p[1]) begin
                                    ch_i_act <= 1'b1;
                                    ch_i_pos <= i_chip;
                                end else begin
                                    ch_q_act <= 1'b1;
                                    ch_q_pos <= i_chip;
                                end
                            end else begin
                                if (p[1]) ch_i_act <= 1'b0;
                                else      ch_q_act <= 1'b0;
                                state <= DRAIN;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oqpsk_halfsine_mod.sv
// Directed bench for oqpsk_halfsine_mod: a CLK_PER_SAMPLE=4 instance with a sample
// scoreboard, and a CLK_PER_SAMPLE=1 instance for the continuous-stream case.
module tb_oqpsk_halfsine_mod;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              a_chip, a_valid, a_ready, a_sv, a_busy, a_done;
    logic signed [3:0] a_i, a_q;
    logic [1:0]        a_st;
    logic              b_chip, b_valid, b_ready, b_sv, b_busy, b_done;
    logic signed [3:0] b_i, b_q;
    logic [1:0]        b_st;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tbl_b[12];

    oqpsk_halfsine_mod #(.CLK_PER_SAMPLE(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_chip(a_chip), .i_chip_valid(a_valid),
        .o_chip_ready(a_ready), .o_i(a_i), .o_q(a_q), .o_sample_valid(a_sv),
        .o_busy(a_busy), .o_done(a_done), .o_dbg_state(a_st)
    );

    oqpsk_halfsine_mod #(.CLK_PER_SAMPLE(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_chip(b_chip), .i_chip_valid(b_valid),
        .o_chip_ready(b_ready), .o_i(b_i), .o_q(b_q), .o_sample_valid(b_sv),
        .o_busy(b_busy), .o_done(b_done), .o_dbg_state(b_st)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [3:0] ei, input logic signed [3:0] eq);
        exp_q.push_back({ei, eq});
    endtask

    // scoreboard for instance A: every strobed sample must match the next expected one
    always @(negedge clk) begin
        if (rst_n && a_sv) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL a_unexpected_sample observed=%0h expected=none", {a_i, a_q});
            end else begin
                check("a_sample", {a_i, a_q}, exp_q.pop_front());
            end
        end
    end

    // driver: present chip c until accepted; toggle i_chip randomly while ready is low
    task automatic send_chip_a(input logic c, input bit hold);
        bit sent;
        sent    = 1'b0;
        a_valid = 1'b1;
        for (int n = 0; n < 64 && !sent; n++) begin
            if (a_ready) begin
                a_chip = c;
                step();
                sent = 1'b1;
            end else begin
                a_chip = 1'($urandom_range(0, 1));
                step();
            end
        end
        if (!hold) a_valid = 1'b0;
        if (!sent) begin
            total++;
            bad++;
            $error("FAIL a_ready_timeout observed=0 expected=1");
        end
    endtask

    task automatic wait_done_a();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            step();
            if (a_done) seen = 1'b1;
        end
        check("a_done_pulse", {7'd0, a_done}, 8'd1);
        check("a_busy_at_done", {7'd0, a_busy}, 8'd0);
        step();
        check("a_done_one_cycle", {7'd0, a_done}, 8'd0);
        check("a_all_samples_seen", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        tbl_b[0]  = 8'h00; tbl_b[1]  = 8'h50; tbl_b[2]  = 8'h70; tbl_b[3]  = 8'h55;
        tbl_b[4]  = 8'h07; tbl_b[5]  = 8'h55; tbl_b[6]  = 8'h70; tbl_b[7]  = 8'h55;
        tbl_b[8]  = 8'h07; tbl_b[9]  = 8'h55; tbl_b[10] = 8'h70; tbl_b[11] = 8'h55;
        rst_n = 1'b0; a_chip = 1'b0; a_valid = 1'b0; b_chip = 1'b0; b_valid = 1'b0;
        step();
        step();

        // reset state
        check("rst_io",    {a_i, a_q}, 8'h00);
        check("rst_sv",    {7'd0, a_sv}, 8'd0);
        check("rst_done",  {7'd0, a_done}, 8'd0);
        check("rst_busy",  {7'd0, a_busy}, 8'd0);
        check("rst_ready", {7'd0, a_ready}, 8'd1);
        check("rst_state", {6'd0, a_st}, 8'd0);
        rst_n = 1'b1;
        step();

        // chips 1,0 then underflow; first-sample latency and sample period
        push(4'sd0, 4'sd0);  push(4'sd5, 4'sd0);  push(4'sd7, 4'sd0);   push(4'sd5, -4'sd5);
        push(4'sd0, -4'sd7); push(4'sd0, -4'sd5); push(4'sd0, 4'sd0);
        send_chip_a(1'b1, 1'b0);
        check("run_busy",  {7'd0, a_busy}, 8'd1);
        check("run_ready", {7'd0, a_ready}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("latency_quiet", {7'd0, a_sv}, 8'd0);
        end
        step();
        check("latency_first", {7'd0, a_sv}, 8'd1);
        send_chip_a(1'b0, 1'b0);
        check("period_second", {7'd0, a_sv}, 8'd1);
        wait_done_a();

        // valid held high across slots with i_chip toggling in between: I1 Q0 I0 Q1
        push(4'sd0, 4'sd0);   push(4'sd5, 4'sd0);   push(4'sd7, 4'sd0);  push(4'sd5, -4'sd5);
        push(4'sd0, -4'sd7);  push(-4'sd5, -4'sd5); push(-4'sd7, 4'sd0); push(-4'sd5, 4'sd5);
        push(4'sd0, 4'sd7);   push(4'sd0, 4'sd5);   push(4'sd0, 4'sd0);
        send_chip_a(1'b1, 1'b1);
        check("ready_low_between_slots", {7'd0, a_ready}, 8'd0);
        send_chip_a(1'b0, 1'b1);
        send_chip_a(1'b0, 1'b1);
        send_chip_a(1'b1, 1'b1);
        a_valid = 1'b0;
        wait_done_a();

        // asynchronous reset mid-RUN, then a fresh chip 0
        push(4'sd0, 4'sd0); push(4'sd5, 4'sd0);
        send_chip_a(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step();
        a_valid = 1'b0;
        check("hold_between_ticks", {a_i, a_q}, 8'h50);
        check("still_run", {6'd0, a_st}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_io",   {a_i, a_q}, 8'h00);
        check("async_rst_busy", {7'd0, a_busy}, 8'd0);
        check("async_rst_sv",   {7'd0, a_sv}, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        check("post_rst_ready", {7'd0, a_ready}, 8'd1);
        check("post_rst_busy",  {7'd0, a_busy}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_residual", {7'd0, a_sv}, 8'd0);
        end
        push(4'sd0, 4'sd0); push(-4'sd5, 4'sd0); push(-4'sd7, 4'sd0); push(-4'sd5, 4'sd0);
        push(4'sd0, 4'sd0);
        send_chip_a(1'b0, 1'b0);
        wait_done_a();

        // CLK_PER_SAMPLE=1 continuous stream of ones
        b_chip  = 1'b1;
        b_valid = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            check("b_sv",     {7'd0, b_sv}, 8'd1);
            check("b_sample", {b_i, b_q}, tbl_b[k]);
            check("b_ready",  {7'd0, b_ready}, {7'd0, (k % 2 == 0)});
        end
        check("b_no_drain", {6'd0, b_st}, 8'd1);
        b_valid = 1'b0;
        for (int n = 0; n < 20 && !b_done; n++) step();
        check("b_done", {7'd0, b_done}, 8'd1);
        step();
        check("b_idle", {7'd0, b_busy}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oqpsk_halfsine_mod.md
OQPSK_HALFSINE_MOD -- requirements
Module: oqpsk_halfsine_mod

Interface
REQ-001 SHALL have parameter CLK_PER_SAMPLE, default 4, clock cycles per output sample (legal range >= 1).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_chip  input  1  chip value (1 -> positive pulse, 0 -> negative pulse).
REQ-005 SHALL have port i_chip_valid  input  1  i_chip is valid.
REQ-006 SHALL have port o_chip_ready  output  1  block accepts i_chip this cycle (combinational from state/counters only).
REQ-007 SHALL have port o_i  output  signed 4  in-phase sample.
REQ-008 SHALL have port o_q  output  signed 4  quadrature sample.
REQ-009 SHALL have port o_sample_valid  output  1  one-cycle strobe per new o_i/o_q sample.
REQ-010 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse on return to IDLE.

Function
REQ-012 Chip transfer SHALL occur only on a clock edge with i_chip_valid=1 and o_chip_ready=1; chips SHALL be alternately assigned to I and Q, starting with I.
REQ-013 Half-sine table H[0..3] = {0, 5, 7, 5}; sign s = +1 for chip 1, -1 for chip 0, 0 for an inactive channel.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-015 IDLE: o_chip_ready=1. On transfer: load the I chip, set phase p=0, clear the sample divider, mark Q inactive, go to RUN.
REQ-016 The divider SHALL count 0..CLK_PER_SAMPLE-1 in RUN and DRAIN. "Tick" = divider at CLK_PER_SAMPLE-1.
REQ-017 At each tick in RUN, the block SHALL register o_i = sI*H[p] and o_q = sQ*H[(p+2) mod 4], pulse o_sample_valid in the following cycle, then advance p modulo 4.
REQ-018 In RUN, o_chip_ready SHALL be 1 only in a tick cycle with p=1 (loads Q, used from p=2) or p=3 (loads I, used from p=0). It SHALL be 0 at all other RUN/DRAIN cycles.
REQ-019 If i_chip_valid=0 in a RUN ready cycle (underflow), the channel being reloaded SHALL become inactive and the FSM SHALL enter DRAIN. p advances normally.
REQ-020 DRAIN SHALL emit exactly 3 more ticks:
- two samples completing the other channel's pulse per REQ-017;
- then one sample with o_i=0, o_q=0;
- then go to IDLE with o_done pulsed.
REQ-021 o_i/o_q SHALL hold their value between ticks.
REQ-022 First-sample latency SHALL be CLK_PER_SAMPLE cycles from the IDLE transfer edge to o_sample_valid=1.
REQ-023 A continuous stream with valid always high SHALL produce uninterrupted samples, one per CLK_PER_SAMPLE cycles, with no DRAIN.
REQ-024 Products SHALL stay within the range -7..+7; no saturation logic is needed.
REQ-025 i_chip SHALL be ignored whenever o_chip_ready=0.

Reset
REQ-026 While i_rst_n=0, regardless of clock:
- state=IDLE, p=0, divider=0, both channels inactive;
- o_i=0, o_q=0, o_sample_valid=0, o_done=0, o_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort immediately. After release, the block SHALL be in IDLE with o_chip_ready=1 and no residual samples.

Verification
REQ-028 N=4; chips 1,0 then valid low -> samples (0,0),(5,0),(7,0),(5,-5),(0,-7),(0,-5),(0,0); then o_done, o_busy=0.
REQ-029 N=4; transfer chip 1 at cycle 0 -> o_sample_valid first high at cycle 4, then every 4 cycles.
REQ-030 N=1; chips 1,1,1,1,... valid continuously -> steady state repeats (0,7),(5,5),(7,0),(5,5); o_chip_ready high every other cycle; no DRAIN.
REQ-031 N=4; valid held high with ready low between ready slots -> exactly one chip consumed per ready cycle; i_chip toggling between slots has no effect.
REQ-032 N=4; reset asserted asynchronously mid-RUN (between edges) -> outputs 0 and o_busy=0 immediately; after release a new chip 0 yields first sample (0,0), then (-5,0).
